instr_fetch_stage: RTL

//  RV32I fetch stage and IF/ID pipeline register. Holds the PC, fetches

---
 rtl/instr_fetch_stage.sv | 136 +++++++++++++
 1 files changed

// File: rtl/instr_fetch_stage.sv
// RV32I fetch stage with IF/ID pipeline register, one-entry skid buffer for stalled acks.
// Optional FETCH_PERF_EN adds fetch_count / bubble_count performance counters.
module instr_fetch_stage #(
    parameter int unsigned     XLEN      = 32,
    parameter logic [XLEN-1:0] RESET_PC  = '0,
    parameter logic [31:0]     NOP_INSTR = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic [31:0]     imem_rdata,
    input  logic            imem_ack,
    input  logic            stall,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            if_id_valid,
    output logic [XLEN-1:0] if_id_pc,
    output logic [31:0]     if_id_instr,
    output logic [6:0]      if_id_opcode
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]     fetch_count,
    output logic [31:0]     bubble_count
`endif
);

    localparam int unsigned ILEN = 32;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e          state_q;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] if_id_pc_q;
    logic [ILEN-1:0] if_id_instr_q;
    logic            if_id_valid_q;
    logic [XLEN-1:0] skid_pc_q;
    logic [ILEN-1:0] skid_instr_q;
    logic [XLEN-1:0] pc_plus4_d;
    logic [XLEN-1:0] redirect_pc_d;

    assign pc_plus4_d    = pc_q + XLEN'(4);
    assign redirect_pc_d = {redirect_pc[XLEN-1:2], 2'b00};

    assign imem_req     = (state_q == REQ);
    assign imem_addr    = pc_q;
    assign if_id_valid  = if_id_valid_q;
    assign if_id_pc     = if_id_pc_q;
    assign if_id_instr  = if_id_instr_q;
    assign if_id_opcode = if_id_instr_q[6:0];

    // Fetch FSM, pc and IF/ID register; redirect outranks ack and stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= BOOT;
            pc_q          <= RESET_PC;
            if_id_valid_q <= 1'b0;
            if_id_pc_q    <= RESET_PC;
            if_id_instr_q <= NOP_INSTR;
            skid_pc_q     <= '0;
            skid_instr_q  <= '0;
        end else begin
            unique case (state_q)
                BOOT: state_q <= REQ;
                REQ: begin
                    if (redirect) begin
                        pc_q          <= redirect_pc_d;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                    end else if (imem_ack && !stall) begin
                        if_id_valid_q <= 1'b1;
                        if_id_pc_q    <= pc_q;
                        if_id_instr_q <= imem_rdata;
                        pc_q          <= pc_plus4_d;
                    end else if (imem_ack) begin
                        skid_pc_q    <= pc_q;
                        skid_instr_q <= imem_rdata;
                        pc_q         <= pc_plus4_d;
                        state_q      <= HOLD;
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q          <= redirect_pc_d;
                        if_id_valid_q <= 1'b0;
                        if_id_instr_q <= NOP_INSTR;
                        state_q       <= REQ;
                    end else if (!stall) begin
                        if_id_valid_q <= 1'b1;
                        if_id_pc_q    <= skid_pc_q;
                        if_id_instr_q <= skid_instr_q;
                        state_q       <= REQ;
                    end
                end
                default: state_q <= BOOT;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    logic fetch_accept_c;
    logic bubble_load_c;

    // An ack counts as fetched unless a redirect discards it in the same cycle.
    always_comb begin
        fetch_accept_c = 1'b0;
        bubble_load_c  = 1'b0;
        unique case (state_q)
            REQ: begin
                fetch_accept_c = imem_ack & ~redirect;
                bubble_load_c  = redirect | (~imem_ack & ~stall);
            end
            HOLD:    bubble_load_c = redirect;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_count  <= '0;
            bubble_count <= '0;
        end else begin
            if (fetch_accept_c) fetch_count <= fetch_count + 32'd1;
            if (bubble_load_c)  bubble_count <= bubble_count + 32'd1;
        end
    end
`endif

endmodule
